imu_sample_filter: RTL and testbench
====================================

# imu_sample_filter

Moving-average filter stage directly downstream of `i2c_device_driver`. Captures each new BNO055 Euler-angle and gyro-rate sample on the driver's `valid_strobe` and returns the driver's `next_mod_active` acknowledge. Averages each channel over a power-of-two window using one shared accumulator, one channel per cycle. Presents filtered signed data to the flight-control stage with its own strobe/acknowledge handshake.

## Interface
Parameters:
- `DATA_W`, 16: sample width, two's complement.
- `AVG_LOG2`, 2: log2 of averaging window; window = 4 samples.

Ports (`sys_clk` only clock; `reset` synchronous, active-high):
- `sys_clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `imu_valid_strobe` in 1: driver `valid_strobe`; may be a multi-cycle level.
- `euler_angle_x/y/z` in 16 each: raw Euler angles.
- `gyro_rate_x/y/z` in 16 each: raw gyro rates.
- `imu_active` out 1: one-cycle acknowledge to driver `next_mod_active`.
- `filt_euler_x/y/z` out 16 each: filtered angles.
- `filt_gyro_x/y/z` out 16 each: filtered gyro rates.
- `filt_valid_strobe` out 1: one-cycle pulse when new filtered set is on the outputs.
- `next_mod_active` in 1: downstream acknowledge.
- `filt_primed` out 1: high once the window has been filled since reset.
- `busy` out 1: high in any state other than IDLE.
- `overrun_cnt` out 8: count of dropped samples, saturating.

## Operation
- Rising-edge detection: `strobe_q` holds the last-cycle strobe; `strobe_rise = imu_valid_strobe & ~strobe_q`.
- FSM states: IDLE, ACCUM, OUTPUT, WAIT_ACK.
- IDLE, on `strobe_rise`: latch all six raw inputs, pulse `imu_active`, clear `ch_idx`, go to ACCUM.
- ACCUM: one channel per cycle, in order ex, ey, ez, gx, gy, gz.
  - `sum[ch] <= sum[ch] - hist[ch][wr_ptr] + raw[ch]`.
  - `hist[ch][wr_ptr] <= raw[ch]`.
  - After the last channel, go to OUTPUT.
- OUTPUT:
  - Register `filt_* = sum[ch] >>> AVG_LOG2` (arithmetic shift, truncate toward −inf).
  - Pulse `filt_valid_strobe`.
  - Advance `wr_ptr`, which wraps from 2^AVG_LOG2−1 to 0.
  - Increment `fill_cnt`, saturating; `filt_primed` rises when `fill_cnt` reaches 2^AVG_LOG2.
  - Go to WAIT_ACK.
- WAIT_ACK: stay until `next_mod_active`=1, then go to IDLE.
- Arithmetic: `sum` is DATA_W+AVG_LOG2 bits signed, so it cannot overflow. History starts at zero, so outputs ramp up before the window is primed.
- Overrun: `strobe_rise` in ACCUM, OUTPUT or WAIT_ACK (including the cycle `next_mod_active` arrives) drops the sample. No `imu_active` pulse; `overrun_cnt` increments and saturates at 255.
- Reset (any cycle, including mid-ACCUM): state IDLE; all outputs 0; `sum`, `hist`, `wr_ptr`, `fill_cnt`, `strobe_q` cleared. No pulses issued on reset.

## Timing
- `strobe_rise` seen at edge N (IDLE): `imu_active`=1 for cycle N..N+1.
- ACCUM occupies edges N+1..N+6.
- OUTPUT at edge N+7: `filt_*` valid and `filt_valid_strobe`=1 for one cycle.
- Latency is 7 cycles, or 4 with the gyro path compiled out.
- Minimum sample period is 8 cycles plus downstream acknowledge time.
- `next_mod_active` seen at edge M in WAIT_ACK: IDLE at M+1; a `strobe_rise` at M+1 is accepted.
- `filt_*` hold their value until the next OUTPUT.

## Configuration
- `IMU_FILTER_GYRO_EN` defined: all six channels filtered; ACCUM lasts 6 cycles.
- Not defined:
  - Gyro channels bypass the filter; `filt_gyro_*` register the latched raw value at OUTPUT.
  - ACCUM covers only ex/ey/ez (3 cycles).
  - Gyro history and sum storage are not instantiated.

## Structure
- `common_defines.v` holds: FSM state encodings, `IMU_FILT_CHANNELS` (6 or 3 per macro), and `LOW`/`HIGH`.
- Sub-module `imu_ring_buffer`:
  - History storage indexed by channel and `wr_ptr`.
  - One read port, one write port.
  - Owns `wr_ptr` and the wrap logic.
- Top level holds the FSM, the shared add/subtract accumulator and the handshakes.

## Test plan
- Four strobes, each acked at once, `euler_angle_x`=16: `filt_euler_x` = 4, 8, 12, 16; `filt_primed` rises with the 4th `filt_valid_strobe`.
- One strobe, `gyro_rate_x`=16'hFFF8 (−8): `filt_gyro_x`=16'hFFFE. After four such samples: 16'hFFF8.
- Strobe held high 20 cycles: exactly one `imu_active` pulse, and `filt_valid_strobe` 7 cycles after the rise.
- Second strobe rise 3 cycles after the first: `overrun_cnt`=1, one `filt_valid_strobe`; 300 dropped strobes: `overrun_cnt`=255.
- `next_mod_active` held low 100 cycles after `filt_valid_strobe`: `busy`=1 and strobes dropped. Then ack → IDLE next cycle, and the following strobe is accepted.
- `reset` asserted at ACCUM cycle 3: all outputs 0 next cycle, no `filt_valid_strobe`. The next sample of 16 yields `filt_euler_x`=4.

Source files
------------

// File: rtl/imu_sample_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imu_sample_filter_pkg
//  Description : Shared constants for the IMU moving-average filter. Holds the
//                FSM state encodings, the number of filtered channels and the
//                LOW/HIGH logic levels, plus a saturating counter helper.
//                IMU_FILTER_GYRO_EN selects 6 filtered channels (euler + gyro)
//                instead of 3 (euler only).
//  Revision    : 1.0  initial release
// ============================================================================
package imu_sample_filter_pkg;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    // FSM state encodings
    localparam int         c_STATE_W     = 2;
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ACCUM    = 2'd1;
    localparam logic [1:0] c_ST_OUTPUT   = 2'd2;
    localparam logic [1:0] c_ST_WAIT_ACK = 2'd3;

`ifdef IMU_FILTER_GYRO_EN
    localparam int IMU_FILT_CHANNELS = 6;
`else
    localparam int IMU_FILT_CHANNELS = 3;
`endif

    // 8-bit counter increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imu_sample_filter_ring_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : imu_ring_buffer
//  Description : Per-channel sample history for the moving-average filter.
//                Storage is indexed by channel and a shared write pointer; the
//                read port returns the oldest sample of the addressed channel
//                (the slot about to be overwritten). The write pointer advances
//                once per completed sample set and wraps at 2^DEPTH_LOG2-1.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_rd_ch         - read channel index
//                o_rd_data       - history[i_rd_ch][wr_ptr]
//                i_wr_en/i_wr_ch - write enable / write channel index
//                i_wr_data       - sample written at history[i_wr_ch][wr_ptr]
//                i_advance       - step the write pointer
//  Revision    : 1.0  initial release
// ============================================================================
module imu_ring_buffer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 2,
    parameter int CHANNELS   = 6,
    parameter int CH_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_W-1:0]   i_rd_ch,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_advance
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     r_mem [CHANNELS][c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;

    // Asynchronous read: the slot under the write pointer is the sample that
    // falls out of the window on this update.
    assign o_rd_data = r_mem[i_rd_ch][r_wr_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int d = 0; d < c_DEPTH; d++) begin
                    r_mem[c][d] <= '0;
                end
            end
            r_wr_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_ch][r_wr_ptr] <= i_wr_data;
            end
            if (i_advance) begin
                if (r_wr_ptr == DEPTH_LOG2'(c_DEPTH - 1)) begin
                    r_wr_ptr <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imu_sample_filter.sv
`default_nettype none
// ============================================================================
//  Module      : imu_sample_filter
//  Description : Moving-average filter between the BNO055 I2C driver and the
//                flight-control stage. Captures a raw sample set on the rising
//                edge of imu_valid_strobe, acknowledges it with a one-cycle
//                imu_active pulse, updates one channel's running sum per cycle
//                through a shared add/subtract accumulator, then presents the
//                averaged set with a one-cycle filt_valid_strobe and waits for
//                next_mod_active. Strobes arriving while busy are dropped and
//                counted in overrun_cnt (saturating).
//  Config      : IMU_FILTER_GYRO_EN defined  -> euler and gyro filtered
//                                               (latency 7 cycles)
//                IMU_FILTER_GYRO_EN undefined-> gyro passed through unfiltered
//                                               (latency 4 cycles)
//  Ports       : sys_clk, reset (sync, active-high)
//                imu_valid_strobe, euler_angle_*, gyro_rate_*  raw input side
//                imu_active                                     input ack
//                filt_euler_*, filt_gyro_*, filt_valid_strobe   output side
//                next_mod_active                                output ack
//                filt_primed, busy, overrun_cnt                 status
//  Revision    : 1.0  initial release
// ============================================================================
module imu_sample_filter
    import imu_sample_filter_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              imu_valid_strobe,
    input  logic [DATA_W-1:0] euler_angle_x,
    input  logic [DATA_W-1:0] euler_angle_y,
    input  logic [DATA_W-1:0] euler_angle_z,
    input  logic [DATA_W-1:0] gyro_rate_x,
    input  logic [DATA_W-1:0] gyro_rate_y,
    input  logic [DATA_W-1:0] gyro_rate_z,
    output logic              imu_active,
    output logic [DATA_W-1:0] filt_euler_x,
    output logic [DATA_W-1:0] filt_euler_y,
    output logic [DATA_W-1:0] filt_euler_z,
    output logic [DATA_W-1:0] filt_gyro_x,
    output logic [DATA_W-1:0] filt_gyro_y,
    output logic [DATA_W-1:0] filt_gyro_z,
    output logic              filt_valid_strobe,
    input  logic              next_mod_active,
    output logic              filt_primed,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);

    localparam int c_SUM_W  = DATA_W + AVG_LOG2;
    localparam int c_WINDOW = 1 << AVG_LOG2;
    localparam int c_FILL_W = AVG_LOG2 + 1;
    localparam int c_CH_W   = (IMU_FILT_CHANNELS > 1) ? $clog2(IMU_FILT_CHANNELS) : 1;

    logic [c_STATE_W-1:0]     r_state;
    logic                     r_strobe_q;
    logic                     w_strobe_rise;
    logic [c_CH_W-1:0]        r_ch_idx;
    logic [c_FILL_W-1:0]      r_fill_cnt;

    // Latched raw samples of the filtered channels (ex, ey, ez[, gx, gy, gz])
    logic signed [DATA_W-1:0]  r_raw [IMU_FILT_CHANNELS];
`ifndef IMU_FILTER_GYRO_EN
    // Gyro samples bypass the filter and are only held for the output stage
    logic        [DATA_W-1:0]  r_gyro_raw [3];
`endif
    logic signed [c_SUM_W-1:0] r_sum [IMU_FILT_CHANNELS];

    logic signed [DATA_W-1:0]  w_raw_sel;
    logic signed [DATA_W-1:0]  w_hist;
    logic signed [c_SUM_W-1:0] w_raw_ext;
    logic signed [c_SUM_W-1:0] w_hist_ext;
    logic signed [c_SUM_W-1:0] w_sum_next;
    logic signed [DATA_W-1:0]  w_avg [IMU_FILT_CHANNELS];
    logic                      w_ring_wr_en;
    logic                      w_ring_advance;

    assign w_strobe_rise = imu_valid_strobe & ~r_strobe_q;
    assign busy          = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------
    // Shared accumulator: replace the oldest sample of the current channel
    // with the new one. The sum is wide enough to hold a full window.
    // ------------------------------------------------------------------
    assign w_raw_sel  = r_raw[r_ch_idx];
    assign w_raw_ext  = {{AVG_LOG2{w_raw_sel[DATA_W-1]}}, w_raw_sel};
    assign w_hist_ext = {{AVG_LOG2{w_hist[DATA_W-1]}}, w_hist};
    assign w_sum_next = r_sum[r_ch_idx] - w_hist_ext + w_raw_ext;

    assign w_ring_wr_en   = (r_state == c_ST_ACCUM);
    assign w_ring_advance = (r_state == c_ST_OUTPUT);

    imu_ring_buffer #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (AVG_LOG2),
        .CHANNELS   (IMU_FILT_CHANNELS),
        .CH_W       (c_CH_W)
    ) u_ring (
        .clk        (sys_clk),
        .rst        (reset),
        .i_rd_ch    (r_ch_idx),
        .o_rd_data  (w_hist),
        .i_wr_en    (w_ring_wr_en),
        .i_wr_ch    (r_ch_idx),
        .i_wr_data  (w_raw_sel),
        .i_advance  (w_ring_advance)
    );

    // Average = sum >>> AVG_LOG2 truncated to DATA_W bits, which is exactly
    // the upper DATA_W bits of the sum (floor toward -inf).
    generate
        for (genvar g = 0; g < IMU_FILT_CHANNELS; g++) begin : g_avg
            assign w_avg[g] = r_sum[g][c_SUM_W-1:AVG_LOG2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state           <= c_ST_IDLE;
            r_strobe_q        <= LOW;
            r_ch_idx          <= '0;
            r_fill_cnt        <= '0;
            imu_active        <= LOW;
            filt_valid_strobe <= LOW;
            filt_primed       <= LOW;
            overrun_cnt       <= '0;
            filt_euler_x      <= '0;
            filt_euler_y      <= '0;
            filt_euler_z      <= '0;
            filt_gyro_x       <= '0;
            filt_gyro_y       <= '0;
            filt_gyro_z       <= '0;
            for (int k = 0; k < IMU_FILT_CHANNELS; k++) begin
                r_raw[k] <= '0;
                r_sum[k] <= '0;
            end
`ifndef IMU_FILTER_GYRO_EN
            for (int k = 0; k < 3; k++) begin
                r_gyro_raw[k] <= '0;
            end
`endif
        end else begin
            r_strobe_q        <= imu_valid_strobe;
            imu_active        <= LOW;
            filt_valid_strobe <= LOW;

            // A new sample while the pipeline is occupied is lost
            if (w_strobe_rise && (r_state != c_ST_IDLE)) begin
                overrun_cnt <= sat_inc8(overrun_cnt);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_strobe_rise) begin
                        r_raw[0] <= euler_angle_x;
                        r_raw[1] <= euler_angle_y;
                        r_raw[2] <= euler_angle_z;
`ifdef IMU_FILTER_GYRO_EN
                        r_raw[3] <= gyro_rate_x;
                        r_raw[4] <= gyro_rate_y;
                        r_raw[5] <= gyro_rate_z;
`else
                        r_gyro_raw[0] <= gyro_rate_x;
                        r_gyro_raw[1] <= gyro_rate_y;
                        r_gyro_raw[2] <= gyro_rate_z;
`endif
                        imu_active <= HIGH;
                        r_ch_idx   <= '0;
                        r_state    <= c_ST_ACCUM;
                    end
                end

                c_ST_ACCUM: begin
                    r_sum[r_ch_idx] <= w_sum_next;
                    if (r_ch_idx == c_CH_W'(IMU_FILT_CHANNELS - 1)) begin
                        r_state <= c_ST_OUTPUT;
                    end else begin
                        r_ch_idx <= r_ch_idx + 1'b1;
                    end
                end

                c_ST_OUTPUT: begin
                    filt_euler_x <= w_avg[0];
                    filt_euler_y <= w_avg[1];
                    filt_euler_z <= w_avg[2];
`ifdef IMU_FILTER_GYRO_EN
                    filt_gyro_x  <= w_avg[3];
                    filt_gyro_y  <= w_avg[4];
                    filt_gyro_z  <= w_avg[5];
`else
                    filt_gyro_x  <= r_gyro_raw[0];
                    filt_gyro_y  <= r_gyro_raw[1];
                    filt_gyro_z  <= r_gyro_raw[2];
`endif
                    filt_valid_strobe <= HIGH;
                    if (r_fill_cnt != c_FILL_W'(c_WINDOW)) begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (r_fill_cnt == c_FILL_W'(c_WINDOW - 1)) begin
                            filt_primed <= HIGH;
                        end
                    end
                    r_state <= c_ST_WAIT_ACK;
                end

                c_ST_WAIT_ACK: begin
                    if (next_mod_active) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imu_sample_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imu_sample_filter
//  Description : Directed self-checking bench for imu_sample_filter. Expected
//                values are hand-computed constants; the gyro expectations
//                follow IMU_FILTER_GYRO_EN (filtered vs. passed through).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imu_sample_filter;

`ifdef IMU_FILTER_GYRO_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 4;
`endif

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        imu_valid_strobe = 1'b0;
    logic        next_mod_active = 1'b0;
    logic [15:0] euler_angle_x = '0, euler_angle_y = '0, euler_angle_z = '0;
    logic [15:0] gyro_rate_x = '0, gyro_rate_y = '0, gyro_rate_z = '0;
    logic        imu_active, filt_valid_strobe, filt_primed, busy;
    logic [15:0] filt_euler_x, filt_euler_y, filt_euler_z;
    logic [15:0] filt_gyro_x, filt_gyro_y, filt_gyro_z;
    logic [7:0]  overrun_cnt;

    int   checks = 0;
    int   failures = 0;
    int   n_active = 0;
    int   n_fvs = 0;
    int   last_latency = 0;
    logic primed_at_strobe = 1'b0;

    imu_sample_filter #(.DATA_W(16), .AVG_LOG2(2)) dut (
        .sys_clk           (sys_clk),
        .reset             (reset),
        .imu_valid_strobe  (imu_valid_strobe),
        .euler_angle_x     (euler_angle_x),
        .euler_angle_y     (euler_angle_y),
        .euler_angle_z     (euler_angle_z),
        .gyro_rate_x       (gyro_rate_x),
        .gyro_rate_y       (gyro_rate_y),
        .gyro_rate_z       (gyro_rate_z),
        .imu_active        (imu_active),
        .filt_euler_x      (filt_euler_x),
        .filt_euler_y      (filt_euler_y),
        .filt_euler_z      (filt_euler_z),
        .filt_gyro_x       (filt_gyro_x),
        .filt_gyro_y       (filt_gyro_y),
        .filt_gyro_z       (filt_gyro_z),
        .filt_valid_strobe (filt_valid_strobe),
        .next_mod_active   (next_mod_active),
        .filt_primed       (filt_primed),
        .busy              (busy),
        .overrun_cnt       (overrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters
    always @(posedge sys_clk) begin
        if (imu_active === 1'b1)        n_active = n_active + 1;
        if (filt_valid_strobe === 1'b1) n_fvs = n_fvs + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        imu_valid_strobe = 1'b0;
        next_mod_active = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // One-cycle strobe, wait for the filtered strobe, optionally acknowledge
    task automatic send_sample(input bit do_ack);
        bit found;
        imu_valid_strobe = 1'b1;
        tick();
        checks++;
        if (imu_active !== 1'b1) begin
            failures++;
            $display("FAIL accept_imu_active: got %b expected 1", imu_active);
        end
        imu_valid_strobe = 1'b0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (filt_valid_strobe === 1'b1) begin
                found = 1'b1;
                last_latency = i;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL latency_timeout: no filt_valid_strobe within 20 cycles, expected after %0d", LAT);
        end else if (last_latency != LAT) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected %0d", last_latency, LAT);
        end
        primed_at_strobe = filt_primed;
        if (do_ack) begin
            next_mod_active = 1'b1;
            tick();
            next_mod_active = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL ack_to_idle: busy got %b expected 0", busy);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({imu_active, filt_valid_strobe, busy, filt_primed} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: {active,fvs,busy,primed} got %b expected 0000",
                     {imu_active, filt_valid_strobe, busy, filt_primed});
        end
        checks++;
        if (overrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt);
        end
        checks++;
        if ({filt_euler_x, filt_euler_y, filt_euler_z, filt_gyro_x, filt_gyro_y, filt_gyro_z} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data: filtered outputs got %h expected 0",
                     {filt_euler_x, filt_euler_y, filt_euler_z, filt_gyro_x, filt_gyro_y, filt_gyro_z});
        end
    endtask

    // Window ramp-up: 16 -> 4,8,12,16 ; -4 -> -1..-4 ; 5 -> 1,2,3,5 (floor)
    task automatic test_ramp();
        logic [15:0] exp_x [4];
        logic [15:0] exp_y [4];
        logic [15:0] exp_z [4];
        exp_x = '{16'd4, 16'd8, 16'd12, 16'd16};
        exp_y = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC};
        exp_z = '{16'd1, 16'd2, 16'd3, 16'd5};
        apply_reset();
        euler_angle_x = 16'd16;
        euler_angle_y = 16'hFFFC;
        euler_angle_z = 16'd5;
        for (int k = 0; k < 4; k++) begin
            send_sample(1'b1);
            checks++;
            if ({filt_euler_x, filt_euler_y, filt_euler_z} !== {exp_x[k], exp_y[k], exp_z[k]}) begin
                failures++;
                $display("FAIL ramp_%0d: euler x/y/z got %h/%h/%h expected %h/%h/%h", k,
                         filt_euler_x, filt_euler_y, filt_euler_z, exp_x[k], exp_y[k], exp_z[k]);
            end
            checks++;
            if (primed_at_strobe !== (k == 3)) begin
                failures++;
                $display("FAIL primed_%0d: got %b expected %b", k, primed_at_strobe, (k == 3));
            end
        end
    endtask

    task automatic test_gyro();
        logic [15:0] exp_gx_first, exp_gx_last, exp_gy_first, exp_gy_last;
`ifdef IMU_FILTER_GYRO_EN
        exp_gx_first = 16'hFFFE; exp_gx_last = 16'hFFF8;
        exp_gy_first = 16'd0;    exp_gy_last = 16'd3;
`else
        exp_gx_first = 16'hFFF8; exp_gx_last = 16'hFFF8;
        exp_gy_first = 16'd3;    exp_gy_last = 16'd3;
`endif
        apply_reset();
        euler_angle_x = '0; euler_angle_y = '0; euler_angle_z = '0;
        gyro_rate_x = 16'hFFF8;
        gyro_rate_y = 16'd3;
        for (int k = 0; k < 4; k++) begin
            send_sample(1'b1);
            if (k == 0) begin
                checks++;
                if ({filt_gyro_x, filt_gyro_y} !== {exp_gx_first, exp_gy_first}) begin
                    failures++;
                    $display("FAIL gyro_first: gx/gy got %h/%h expected %h/%h",
                             filt_gyro_x, filt_gyro_y, exp_gx_first, exp_gy_first);
                end
            end
        end
        checks++;
        if ({filt_gyro_x, filt_gyro_y} !== {exp_gx_last, exp_gy_last}) begin
            failures++;
            $display("FAIL gyro_window: gx/gy got %h/%h expected %h/%h",
                     filt_gyro_x, filt_gyro_y, exp_gx_last, exp_gy_last);
        end
        gyro_rate_x = '0;
        gyro_rate_y = '0;
    endtask

    task automatic test_held_strobe();
        int a0, f0, first;
        apply_reset();
        a0 = n_active;
        f0 = n_fvs;
        first = 0;
        imu_valid_strobe = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (filt_valid_strobe === 1'b1 && first == 0) first = i;
            next_mod_active = filt_valid_strobe;
        end
        imu_valid_strobe = 1'b0;
        next_mod_active = 1'b0;
        repeat (3) tick();
        checks++;
        if (n_active - a0 != 1) begin
            failures++;
            $display("FAIL held_active_pulses: got %0d expected 1", n_active - a0);
        end
        checks++;
        if (first != LAT + 1) begin
            failures++;
            $display("FAIL held_latency: got %0d expected %0d", first, LAT + 1);
        end
        checks++;
        if (n_fvs - f0 != 1 || overrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL held_single_set: fvs=%0d overrun=%0d expected 1 and 0", n_fvs - f0, overrun_cnt);
        end
    endtask

    task automatic test_overrun();
        int a0, f0;
        bit found;
        apply_reset();
        a0 = n_active;
        f0 = n_fvs;
        imu_valid_strobe = 1'b1; tick();
        imu_valid_strobe = 1'b0; tick(); tick();
        imu_valid_strobe = 1'b1; tick();
        imu_valid_strobe = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (filt_valid_strobe === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL overrun_timeout: no filt_valid_strobe within 20 cycles");
        end
        next_mod_active = 1'b1; tick();
        next_mod_active = 1'b0;
        repeat (3) tick();
        checks++;
        if (overrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL overrun_one: got %0d expected 1", overrun_cnt);
        end
        checks++;
        if (n_active - a0 != 1 || n_fvs - f0 != 1) begin
            failures++;
            $display("FAIL overrun_pulses: active=%0d fvs=%0d expected 1 and 1", n_active - a0, n_fvs - f0);
        end
    endtask

    // Continues from test_overrun (overrun_cnt = 1)
    task automatic test_wait_ack();
        int a0;
        send_sample(1'b0);
        repeat (100) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_ack_busy: got %b expected 1", busy);
        end
        a0 = n_active;
        for (int i = 0; i < 300; i++) begin
            imu_valid_strobe = 1'b1; tick();
            imu_valid_strobe = 1'b0; tick();
        end
        checks++;
        if (overrun_cnt !== 8'd255) begin
            failures++;
            $display("FAIL overrun_saturate: got %0d expected 255", overrun_cnt);
        end
        checks++;
        if (n_active != a0) begin
            failures++;
            $display("FAIL dropped_no_ack: imu_active pulses got %0d expected 0", n_active - a0);
        end
        next_mod_active = 1'b1; tick();
        next_mod_active = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL late_ack_idle: busy got %b expected 0", busy);
        end
        send_sample(1'b1);
    endtask

    task automatic test_reset_mid_accum();
        int f0;
        apply_reset();
        euler_angle_x = 16'd16;
        send_sample(1'b1);
        checks++;
        if (filt_euler_x !== 16'd4) begin
            failures++;
            $display("FAIL pre_reset_sample: got %h expected 0004", filt_euler_x);
        end
        f0 = n_fvs;
        imu_valid_strobe = 1'b1; tick();
        imu_valid_strobe = 1'b0; tick(); tick();
        reset = 1'b1; tick();
        checks++;
        if ({imu_active, filt_valid_strobe, busy, filt_primed} !== 4'b0000 ||
            filt_euler_x !== 16'd0 || overrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_accum_reset: ctrl=%b ex=%h ovr=%0d expected 0000/0000/0",
                     {imu_active, filt_valid_strobe, busy, filt_primed}, filt_euler_x, overrun_cnt);
        end
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (n_fvs != f0) begin
            failures++;
            $display("FAIL aborted_no_strobe: fvs got %0d expected 0", n_fvs - f0);
        end
        send_sample(1'b1);
        checks++;
        if (filt_euler_x !== 16'd4) begin
            failures++;
            $display("FAIL post_reset_sample: got %h expected 0004", filt_euler_x);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gyro();
        test_held_strobe();
        test_overrun();
        test_wait_ack();
        test_reset_mid_accum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
